// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   alu_op_e    : opcode encodings driven on seq_alu.anOperand
//   alu_flags_t : packed {v,c,n,z} status flags, bit order matches FLAG_* indices
//   alu_state_e : execute-unit FSM states
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_MOV  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_NOT  = 5'd5,
    OP_INC  = 5'd6,
    OP_DEC  = 5'd7,
    OP_MUL  = 5'd8,
    OP_MOVU = 5'd9,
    OP_MOVL = 5'd10
  } alu_op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle.
//   clk     : clock
//   rst_n   : synchronous active-low reset, clears all multiplier state
//   start   : load operands and restart the iteration counter
//   en      : advance one iteration (ignored once the final count is reached)
//   a, b    : operands, sampled only on start
//   done    : counter sits at the final iteration
//   product : low WIDTH bits of a*b, valid while done (includes the last partial product)
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] addend;

  // The final partial product is folded in combinationally so the owner can
  // capture the full product on the same edge that completes the count.
  assign addend  = b_sh[0] ? a_sh : '0;
  assign product = acc + addend;
  assign done    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (start) begin
      acc  <= '0;
      a_sh <= a;
      b_sh <= b;
      cnt  <= '0;
    end else if (en && !done) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle execute unit.
//   aClock      : clock, rising edge
//   aResetN     : synchronous active-low reset
//   anInValid / anInReady   : operation handshake (opcode anOperand, operands aA, aB)
//   anOutValid / anOutReady : result handshake (anOutput, anOutFault, aFlags)
//   aFlags      : {V,C,N,Z}
// Build option: define ALU_FLAGS_EN for registered status flags; otherwise aFlags is 0.
// Single-cycle ops appear one cycle after accept; MUL appears WIDTH cycles after accept.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 5
) (
  input  logic             aClock,
  input  logic             aResetN,
  input  logic             anInValid,
  output logic             anInReady,
  input  logic [OP_W-1:0]  anOperand,
  input  logic [WIDTH-1:0] aA,
  input  logic [WIDTH-1:0] aB,
  output logic             anOutValid,
  input  logic             anOutReady,
  output logic [WIDTH-1:0] anOutput,
  output logic             anOutFault,
  output logic [3:0]       aFlags
);

  localparam int H = WIDTH / 2;

  alu_state_e       state;
  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             fault_p1;

  logic             out_free;
  logic             accept;
  logic             consume;
  logic             is_mul;
  logic             load_alu;
  logic             load_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] res_c;
  logic             fault_c;

  // Output register is free if empty or being drained on this edge.
  assign out_free  = !vld_p1 || anOutReady;
  assign anInReady = (state == ST_IDLE) && out_free;
  assign accept    = anInValid && anInReady;
  assign consume   = vld_p1 && anOutReady;
  assign is_mul    = (anOperand == OP_MUL);
  assign load_alu  = accept && !is_mul;
  assign load_mul  = (state == ST_MUL_BUSY) && mul_done && out_free;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (aClock),
    .rst_n   (aResetN),
    .start   (accept && is_mul),
    .en      (state == ST_MUL_BUSY),
    .a       (aA),
    .b       (aB),
    .done    (mul_done),
    .product (mul_prod)
  );

  // ---- stage p0: single-cycle datapath ----
  always_comb begin
    res_c   = '0;
    fault_c = 1'b0;
    case (anOperand)
      OP_MOV:  res_c = aA;
      OP_ADD:  res_c = aA + aB;
      OP_SUB:  res_c = aA - aB;
      OP_AND:  res_c = aA & aB;
      OP_OR:   res_c = aA | aB;
      OP_NOT:  res_c = ~aA;
      OP_INC:  res_c = aA + WIDTH'(1);
      OP_DEC:  res_c = aA - WIDTH'(1);
      OP_MUL:  res_c = '0;
      OP_MOVU: res_c = {aB[H-1:0], aA[H-1:0]};
      OP_MOVL: res_c = {aA[WIDTH-1:H], aB[H-1:0]};
      default: fault_c = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  alu_flags_t flags_c;
  alu_flags_t flags_p1;

  // Carry/borrow derived from the wrapped result; overflow from sign bits.
  always_comb begin
    flags_c = '0;
    if (!fault_c) begin
      flags_c.z = (res_c == '0);
      flags_c.n = res_c[WIDTH-1];
      case (anOperand)
        OP_ADD: begin
          flags_c.c = (res_c < aA);
          flags_c.v = (aA[WIDTH-1] == aB[WIDTH-1]) && (res_c[WIDTH-1] != aA[WIDTH-1]);
        end
        OP_SUB: begin
          flags_c.c = (aA < aB);
          flags_c.v = (aA[WIDTH-1] != aB[WIDTH-1]) && (res_c[WIDTH-1] != aA[WIDTH-1]);
        end
        OP_INC: begin
          flags_c.c = (aA == '1);
          flags_c.v = !aA[WIDTH-1] && res_c[WIDTH-1];
        end
        OP_DEC: begin
          flags_c.c = (aA == '0);
          flags_c.v = aA[WIDTH-1] && !res_c[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      flags_p1 <= '0;
    end else if (load_alu) begin
      flags_p1 <= flags_c;
    end else if (load_mul) begin
      flags_p1 <= '{v: 1'b0, c: 1'b0, n: mul_prod[WIDTH-1], z: (mul_prod == '0)};
    end
  end

  assign aFlags = flags_p1;
`else
  assign aFlags = '0;
`endif

  // ---- stage p1: FSM and output register ----
  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      state    <= ST_IDLE;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      fault_p1 <= 1'b0;
    end else begin
      if (consume) vld_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state <= ST_MUL_BUSY;
          end else if (load_alu) begin
            vld_p1   <= 1'b1;
            res_p1   <= res_c;
            fault_p1 <= fault_c;
          end
        end
        ST_MUL_BUSY: begin
          // Holds at the final count until the output register can take the product.
          if (load_mul) begin
            state    <= ST_IDLE;
            vld_p1   <= 1'b1;
            res_p1   <= mul_prod;
            fault_p1 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign anOutValid = vld_p1;
  assign anOutput   = res_p1;
  assign anOutFault = fault_p1;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W    = 16;
  localparam int MASK = 65535;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_fault;
  logic [3:0]    flags;

  int n_chk;
  int n_pass;

  // Reference state: output register contents plus cycles left on a multiply.
  logic         m_vld;
  logic [15:0]  m_res;
  logic         m_fault;
  logic [3:0]   m_flags;
  int           m_left;
  logic [15:0]  m_pres;
  logic [3:0]   m_pflags;

  seq_alu #(.WIDTH(W), .OP_W(5)) dut (
    .aClock     (clk),
    .aResetN    (rst_n),
    .anInValid  (in_valid),
    .anInReady  (in_ready),
    .anOperand  (op),
    .aA         (a),
    .aB         (b),
    .anOutValid (out_valid),
    .anOutReady (out_ready),
    .anOutput   (out_data),
    .anOutFault (out_fault),
    .aFlags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Spec-level behaviour of one operation with plain integer arithmetic.
  function automatic void ref_op(input int opc, input int av, input int bv,
                                 output logic [15:0] res, output logic flt,
                                 output logic [3:0] fl);
    longint s;
    int sa, sb;
    logic c, v;
    c = 1'b0; v = 1'b0; flt = 1'b0;
    sa = (av >= 32768) ? av - 65536 : av;
    sb = (bv >= 32768) ? bv - 65536 : bv;
    case (opc)
      0:  s = av;
      1:  begin s = av + bv; c = (s > MASK); v = (sa + sb > 32767) || (sa + sb < -32768); end
      2:  begin s = av - bv; c = (av < bv); v = (sa - sb > 32767) || (sa - sb < -32768); end
      3:  s = av & bv;
      4:  s = av | bv;
      5:  s = (~av) & MASK;
      6:  begin s = av + 1; c = (av == MASK); v = (sa + 1 > 32767); end
      7:  begin s = av - 1; c = (av == 0); v = (sa - 1 < -32768); end
      8:  s = longint'(av) * longint'(bv);
      9:  s = (av & 255) | ((bv & 255) * 256);
      10: s = (av & 65280) | (bv & 255);
      default: begin s = 0; flt = 1'b1; end
    endcase
    res = 16'(s & MASK);
`ifdef ALU_FLAGS_EN
    fl = flt ? 4'b0 : {v, c, res[15], (res == 16'h0)};
`else
    fl = 4'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, check ready, clock, update the model, check outputs.
  task automatic step(input logic v, input logic [4:0] opc, input logic [15:0] av,
                      input logic [15:0] bv, input logic ordy, input logic rn);
    logic exp_rdy, acc, cons, free;
    logic [15:0] r;
    logic f;
    logic [3:0] fl;
    in_valid = v; op = opc; a = av; b = bv; out_ready = ordy; rst_n = rn;
    exp_rdy = (m_left == 0) && (!m_vld || ordy);
    #1;
    if (rn) chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    cons = m_vld && ordy;
    free = !m_vld || ordy;
    acc  = v && exp_rdy;
    if (!rn) begin
      m_vld = 0; m_res = 0; m_fault = 0; m_flags = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (m_left > 1) begin
        m_left--;
        if (cons) m_vld = 0;
      end else if (free) begin
        m_vld = 1; m_res = m_pres; m_fault = 0; m_flags = m_pflags; m_left = 0;
      end
    end else if (acc) begin
      ref_op(int'(opc), int'(av), int'(bv), r, f, fl);
      if (opc == 5'd8) begin
        m_left = W; m_pres = r; m_pflags = fl;
        if (cons) m_vld = 0;
      end else begin
        m_vld = 1; m_res = r; m_fault = f; m_flags = fl;
      end
    end else if (cons) begin
      m_vld = 0;
    end
    #1;
    chk("out_valid", out_valid, m_vld);
    if (m_vld) begin
      chk("out_data", out_data, m_res);
      chk("out_fault", out_fault, m_fault);
      chk("out_flags", flags, m_flags);
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] held;
    n_chk = 0; n_pass = 0;
    m_vld = 0; m_res = 0; m_fault = 0; m_flags = 0; m_left = 0; m_pres = 0; m_pflags = 0;
    in_valid = 0; op = 0; a = 0; b = 0; out_ready = 0; rst_n = 0;

    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out_data, 0);
    chk("rst_fault", out_fault, 0);
    chk("rst_flags", flags, 0);

    step(1, 5'd1, 16'hFFFF, 16'h0001, 1, 1);
    chk("add_wrap", out_data, 16'h0000);
`ifdef ALU_FLAGS_EN
    chk("add_wrap_flags", flags, 4'b0101);
`endif

    step(1, 5'd8, 16'h0012, 16'h0034, 1, 1);
    for (int i = 1; i <= W; i++) step(1, 5'd1, 16'h1111, 16'h2222, 1, 1);
    chk("mul_out", out_data, 16'h03A8);
    chk("mul_valid", out_valid, 1);

    step(1, 5'd9, 16'h1234, 16'h00AB, 1, 1);
    chk("movu", out_data, 16'hAB34);
    step(1, 5'd10, 16'h1234, 16'h00AB, 1, 1);
    chk("movl", out_data, 16'h12AB);
    step(1, 5'd2, 16'h0000, 16'h0001, 1, 1);
    chk("sub_borrow", out_data, 16'hFFFF);
`ifdef ALU_FLAGS_EN
    chk("sub_flags", flags, 4'b0110);
`endif

    step(1, 5'h1F, 16'h5555, 16'hAAAA, 1, 1);
    chk("undef_out", out_data, 16'h0000);
    chk("undef_fault", out_fault, 1);
    step(1, 5'd1, 16'h0001, 16'h0001, 1, 1);
    chk("add_after_fault", out_data, 16'h0002);
    chk("fault_cleared", out_fault, 0);

    step(1, 5'd1, 16'h0100, 16'h0023, 0, 1);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step(1, 5'd3, 16'hF0F0, 16'h0FF0, 0, 1);
      chk("bp_hold", out_data, held);
    end
    step(1, 5'd4, 16'hF000, 16'h000F, 1, 1);
    chk("bp_release", out_data, 16'hF00F);

    step(1, 5'd8, 16'h00FF, 16'h0101, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 5'd0, 16'($urandom), 16'($urandom), 1, 1);
    step(1, 5'd0, 16'h0000, 16'h0000, 1, 0);
    chk("rst_mid_mul_valid", out_valid, 0);
    chk("rst_mid_mul_ready", in_ready, 1);
    for (int i = 0; i < W + 4; i++) step(0, 5'd0, 16'h0000, 16'h0000, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ro;
      ro = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
      step(($urandom_range(0, 3) != 0), ro, pick_operand(), pick_operand(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 499) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
